// File: rtl/mac_pipe.sv
// mac_pipe: two-stage pipelined unsigned multiply-add.
//   mode 0: one result per accepted sample, A*B+C, two clocks after the sample.
//   mode 1: A*B+C accumulated over a frame of ACC_LEN accepted samples; one
//           result two clocks after the frame's last sample, saturated or
//           wrapped to OUT_W bits depending on SAT.
// Handshake: in_valid qualifies A/B/C/mode in the cycle it is high. There is
// no ready/backpressure; every valid sample is taken. out_valid is a one-cycle
// pulse marking a new DATA_OUT/overflow. DATA_OUT and overflow hold between
// pulses.
module mac_pipe #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 17,
    parameter int ACC_LEN = 4,
    parameter int SAT     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [IN_W-1:0]  A,
    input  logic [IN_W-1:0]  B,
    input  logic [IN_W-1:0]  C,
    output logic             out_valid,
    output logic [OUT_W-1:0] DATA_OUT,
    output logic             overflow
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int PAD_P = OUT_W - 2 * IN_W;
    localparam int PAD_C = OUT_W - IN_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);
    localparam logic [OUT_W:0]   MAX_EXT  = {1'b0, {OUT_W{1'b1}}};

    // stage 1 registers
    logic [2*IN_W-1:0] prod;
    logic [IN_W-1:0]   c_r;
    logic              mode_r;
    logic              v1;

    // frame state
    logic [OUT_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic              ovf_flag;

    // stage 2 arithmetic
    logic [OUT_W-1:0]  prod_w;
    logic [OUT_W-1:0]  c_w;
    logic [OUT_W-1:0]  single_sum;
    logic [OUT_W:0]    frame_sum;
    logic              sum_ovf;
    logic [OUT_W-1:0]  acc_next;

    // Stage 2 datapath: per-sample sum and the one-bit-wider frame sum used
    // to detect overflow before clamping or wrapping into the accumulator.
    always_comb begin
        prod_w     = {{PAD_P{1'b0}}, prod};
        c_w        = {{PAD_C{1'b0}}, c_r};
        single_sum = prod_w + c_w;
        frame_sum  = ((count == '0) ? '0 : {1'b0, acc})
                   + {1'b0, prod_w} + {1'b0, c_w};
        sum_ovf    = (frame_sum > MAX_EXT);
        acc_next   = frame_sum[OUT_W-1:0];
        if (sum_ovf && (SAT != 0)) begin
            acc_next = '1;
        end
    end

    // Stage 1: register the full-width product and operands; clear drops the
    // sample presented alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod   <= '0;
            c_r    <= '0;
            mode_r <= 1'b0;
            v1     <= 1'b0;
        end else begin
            prod   <= {{IN_W{1'b0}}, A} * {{IN_W{1'b0}}, B};
            c_r    <= C;
            mode_r <= mode;
            v1     <= in_valid && !clear;
        end
    end

    // Stage 2: emit per-sample results, or accumulate and emit at frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            count     <= '0;
            ovf_flag  <= 1'b0;
            out_valid <= 1'b0;
            DATA_OUT  <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            // Flush the in-flight sample and partial frame; outputs hold.
            acc       <= '0;
            count     <= '0;
            ovf_flag  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (v1) begin
                if (!mode_r) begin
                    // A per-sample result also abandons any partial frame.
                    DATA_OUT  <= single_sum;
                    overflow  <= 1'b0;
                    out_valid <= 1'b1;
                    count     <= '0;
                    ovf_flag  <= 1'b0;
                end else begin
                    acc <= acc_next;
                    if (count == LAST_CNT) begin
                        DATA_OUT  <= acc_next;
                        overflow  <= ovf_flag | sum_ovf;
                        out_valid <= 1'b1;
                        count     <= '0;
                        ovf_flag  <= 1'b0;
                    end else begin
                        count    <= count + CNT_W'(1);
                        ovf_flag <= ovf_flag | sum_ovf;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: drives one saturating and one wrapping mac_pipe from the same
// inputs and compares both against a frame-level arithmetic model.
module tb_mac_pipe;

    localparam int IN_W    = 8;
    localparam int OUT_W   = 17;
    localparam int ACC_LEN = 4;
    localparam longint MAXV = (64'd1 << OUT_W) - 1;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic             mode = 1'b0;
    logic [IN_W-1:0]  a = '0;
    logic [IN_W-1:0]  b = '0;
    logic [IN_W-1:0]  c = '0;

    logic             ov_s, ov_w, of_s, of_w;
    logic [OUT_W-1:0] d_s, d_w;

    mac_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_LEN(ACC_LEN), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .mode(mode),
        .A(a), .B(b), .C(c), .out_valid(ov_s), .DATA_OUT(d_s), .overflow(of_s)
    );

    mac_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_LEN(ACC_LEN), .SAT(0)) dut_wrap (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .mode(mode),
        .A(a), .B(b), .C(c), .out_valid(ov_w), .DATA_OUT(d_w), .overflow(of_w)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] exp_wq[$];
    logic             exp_oq[$];
    logic             exp_valid = 1'b0;
    logic [OUT_W-1:0] hold_s = '0;
    logic [OUT_W-1:0] hold_w = '0;
    logic             hold_o = 1'b0;

    // reference model: a sample accepted on one drive takes effect on the next
    logic   pend_v = 1'b0;
    logic   pend_m = 1'b0;
    longint pend_term = 0;
    longint frame_total = 0;
    int     frame_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_result(input longint total, input logic is_frame);
        logic [OUT_W-1:0] vs, vw;
        logic             o;
        vw = total[OUT_W-1:0];
        vs = (total > MAXV) ? '1 : total[OUT_W-1:0];
        o  = is_frame && (total > MAXV);
        exp_q.push_back(vs);
        exp_wq.push_back(vw);
        exp_oq.push_back(o);
        exp_valid = 1'b1;
    endtask

    task automatic check_outputs();
        check("out_valid_sat", {31'd0, ov_s}, {31'd0, exp_valid});
        check("out_valid_wrap", {31'd0, ov_w}, {31'd0, exp_valid});
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                hold_s = exp_q.pop_front();
                hold_w = exp_wq.pop_front();
                hold_o = exp_oq.pop_front();
            end
        end
        check("data_sat", {15'd0, d_s}, {15'd0, hold_s});
        check("data_wrap", {15'd0, d_w}, {15'd0, hold_w});
        check("ovf_sat", {31'd0, of_s}, {31'd0, hold_o});
        check("ovf_wrap", {31'd0, of_w}, {31'd0, hold_o});
        exp_valid = 1'b0;
    endtask

    task automatic model(input logic rst, input logic clr, input logic vld, input logic md,
                         input logic [IN_W-1:0] ia, input logic [IN_W-1:0] ib,
                         input logic [IN_W-1:0] ic);
        if (rst || clr) begin
            frame_total = 0;
            frame_cnt   = 0;
            if (rst) begin
                hold_s = '0;
                hold_w = '0;
                hold_o = 1'b0;
                exp_q.delete();
                exp_wq.delete();
                exp_oq.delete();
            end
        end else if (pend_v) begin
            if (!pend_m) begin
                frame_total = 0;
                frame_cnt   = 0;
                push_result(pend_term, 1'b0);
            end else begin
                frame_total += pend_term;
                frame_cnt++;
                if (frame_cnt == ACC_LEN) begin
                    push_result(frame_total, 1'b1);
                    frame_total = 0;
                    frame_cnt   = 0;
                end
            end
        end
        pend_v    = vld && !rst && !clr;
        pend_m    = md;
        pend_term = longint'(ia) * longint'(ib) + longint'(ic);
    endtask

    // driver: check last edge's outputs, then present the next input set
    task automatic step(input logic rst, input logic clr, input logic vld, input logic md,
                        input logic [IN_W-1:0] ia, input logic [IN_W-1:0] ib,
                        input logic [IN_W-1:0] ic);
        @(negedge clk);
        check_outputs();
        reset    = rst;
        clear    = clr;
        in_valid = vld;
        mode     = md;
        a        = ia;
        b        = ib;
        c        = ic;
        model(rst, clr, vld, md, ia, ib, ic);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic frame(input int n, input logic [IN_W-1:0] ia, input logic [IN_W-1:0] ib,
                         input logic [IN_W-1:0] ic);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, ia, ib, ic);
    endtask

    initial begin
        logic cur_mode;
        int   r;
        logic rst_r, clr_r, vld_r, md_r;
        logic [IN_W-1:0] ra, rb, rc;

        repeat (3) @(posedge clk);

        // single mode-0 sample, then hold
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd4, 8'd5);
        idle(4);

        // back-to-back mode-0 stream
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1, 8'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2, 8'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd255, 8'd255, 8'd255);
        idle(3);

        // frame with an idle gap after the second sample
        frame(2, 8'd10, 8'd10, 8'd1);
        idle(1);
        frame(2, 8'd10, 8'd10, 8'd1);
        idle(3);

        // overflowing frame: clamp on one DUT, wrap on the other
        frame(4, 8'd255, 8'd255, 8'd255);
        idle(3);

        // partial frame abandoned by a mode-0 sample
        frame(2, 8'd10, 8'd10, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd2, 8'd3);
        frame(4, 8'd1, 8'd1, 8'd0);
        idle(3);

        // clear mid-frame (with a sample presented alongside it)
        frame(3, 8'd1, 8'd1, 8'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'd9, 8'd9, 8'd9);
        idle(2);
        frame(4, 8'd2, 8'd3, 8'd0);
        idle(3);

        // reset mid-frame
        frame(3, 8'd1, 8'd1, 8'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'd9, 8'd9, 8'd9);
        idle(2);
        frame(4, 8'd2, 8'd3, 8'd0);
        idle(3);

        // randomized traffic
        cur_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 199));
            rst_r = (r < 2);
            clr_r = (r >= 2) && (r < 8);
            vld_r = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) cur_mode = ~cur_mode;
            md_r = cur_mode;
            if ($urandom_range(0, 29) == 0) md_r = ~cur_mode;
            ra = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
            rc = 8'($urandom_range(0, 255));
            step(rst_r, clr_r, vld_r, md_r, ra, rb, rc);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
